// File: rtl/int_regfile_sb.sv
// Integer architectural register file with two bypassed read ports, a per-register
// busy-bit scoreboard for in-flight writers, and a committed-instruction counter.
module int_regfile_sb #(
  parameter int unsigned XLEN = 64,
  parameter int unsigned NREG = 32,
  parameter int unsigned CNTW = 64
) (
  input  logic            clk_i,
  input  logic            arst_n_i,
  input  logic            commit_valid_i,
  input  logic            commit_wren_i,
  input  logic [XLEN-1:0] commit_data_i,
  input  logic [4:0]      commit_rdindex_i,
  input  logic            disp_valid_i,
  input  logic            disp_wren_i,
  input  logic [4:0]      disp_rdindex_i,
  input  logic            flush_i,
  input  logic [4:0]      rs1_index_i,
  input  logic [4:0]      rs2_index_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  output logic            rs1_busy_o,
  output logic            rs2_busy_o,
  output logic [CNTW-1:0] commit_cnt_o
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [CNTW-1:0] cnt_q, cnt_d;

  logic commit_we;
  logic disp_set;

  assign commit_we = commit_valid_i && commit_wren_i && (commit_rdindex_i != '0);
  assign disp_set  = disp_valid_i && disp_wren_i && (disp_rdindex_i != '0);

  always_comb begin
    regs_d = regs_q;
    if (commit_we) regs_d[commit_rdindex_i] = commit_data_i;
  end

  // Flush beats dispatch; within a non-flush cycle a dispatch set overrides a
  // commit clear on the same rd because the dispatch is the newer writer.
  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      if (commit_we) busy_d[commit_rdindex_i] = 1'b0;
      if (disp_set)  busy_d[disp_rdindex_i]   = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (commit_valid_i) cnt_d = cnt_q + CNTW'(1);
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    rs1_data_o = '0;
    rs1_busy_o = 1'b0;
    if (rs1_index_i != '0) begin
      if (commit_we && (commit_rdindex_i == rs1_index_i)) begin
        rs1_data_o = commit_data_i;
      end else begin
        rs1_data_o = regs_q[rs1_index_i];
        rs1_busy_o = busy_q[rs1_index_i];
      end
    end
  end

  always_comb begin
    rs2_data_o = '0;
    rs2_busy_o = 1'b0;
    if (rs2_index_i != '0) begin
      if (commit_we && (commit_rdindex_i == rs2_index_i)) begin
        rs2_data_o = commit_data_i;
      end else begin
        rs2_data_o = regs_q[rs2_index_i];
        rs2_busy_o = busy_q[rs2_index_i];
      end
    end
  end

  assign commit_cnt_o = cnt_q;

endmodule

// File: tb/tb_int_regfile_sb.sv
// Directed bench for int_regfile_sb: reset, bypass, x0, scoreboard, flush, async reset.
module tb_int_regfile_sb;

  logic        clk_i = 1'b0;
  logic        arst_n_i;
  logic        commit_valid_i, commit_wren_i;
  logic [63:0] commit_data_i;
  logic [4:0]  commit_rdindex_i;
  logic        disp_valid_i, disp_wren_i;
  logic [4:0]  disp_rdindex_i;
  logic        flush_i;
  logic [4:0]  rs1_index_i, rs2_index_i;
  logic [63:0] rs1_data_o, rs2_data_o;
  logic        rs1_busy_o, rs2_busy_o;
  logic [63:0] commit_cnt_o;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [63:0] exp_cnt = '0;

  always #5 clk_i = ~clk_i;

  int_regfile_sb #(.XLEN(64), .NREG(32), .CNTW(64)) dut (
    .clk_i(clk_i), .arst_n_i(arst_n_i),
    .commit_valid_i(commit_valid_i), .commit_wren_i(commit_wren_i),
    .commit_data_i(commit_data_i), .commit_rdindex_i(commit_rdindex_i),
    .disp_valid_i(disp_valid_i), .disp_wren_i(disp_wren_i),
    .disp_rdindex_i(disp_rdindex_i), .flush_i(flush_i),
    .rs1_index_i(rs1_index_i), .rs2_index_i(rs2_index_i),
    .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
    .rs1_busy_o(rs1_busy_o), .rs2_busy_o(rs2_busy_o),
    .commit_cnt_o(commit_cnt_o)
  );

  // Advance one edge; inputs then change 1ns after the edge.
  task automatic step();
    if (commit_valid_i) exp_cnt = exp_cnt + 64'd1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    commit_valid_i = 0; commit_wren_i = 0; commit_data_i = '0; commit_rdindex_i = '0;
    disp_valid_i = 0; disp_wren_i = 0; disp_rdindex_i = '0; flush_i = 0;
  endtask

  task automatic test_reset();
    idle();
    rs1_index_i = 5'd1; rs2_index_i = 5'd2;
    arst_n_i = 0;
    #12;
    checks++;
    if (rs1_data_o !== 64'd0 || rs1_busy_o !== 1'b0 || commit_cnt_o !== 64'd0) begin
      errors++;
      $display("FAIL reset_during data=%h busy=%b cnt=%0d required 0/0/0", rs1_data_o, rs1_busy_o, commit_cnt_o);
    end
    @(negedge clk_i); arst_n_i = 1;
    exp_cnt = '0;
    step();
    for (int i = 1; i < 32; i++) begin
      rs1_index_i = 5'(i); rs2_index_i = 5'(i);
      #1;
      checks++;
      if (rs1_data_o !== 64'd0 || rs2_data_o !== 64'd0 || rs1_busy_o !== 1'b0 || rs2_busy_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_read x%0d d1=%h d2=%h b1=%b b2=%b required all 0", i, rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o);
      end
    end
    checks++;
    if (commit_cnt_o !== 64'd0) begin
      errors++;
      $display("FAIL reset_cnt got %0d required 0", commit_cnt_o);
    end
  endtask

  task automatic test_bypass();
    commit_valid_i = 1; commit_wren_i = 1; commit_rdindex_i = 5'd5;
    commit_data_i = 64'hDEAD_BEEF_0000_1234;
    rs1_index_i = 5'd5;
    #1;
    checks++;
    if (rs1_data_o !== 64'hDEAD_BEEF_0000_1234) begin
      errors++;
      $display("FAIL bypass_rs1 got %h required %h", rs1_data_o, 64'hDEAD_BEEF_0000_1234);
    end
    step();
    idle();
    #1;
    checks++;
    if (rs1_data_o !== 64'hDEAD_BEEF_0000_1234) begin
      errors++;
      $display("FAIL array_rs1 got %h required %h", rs1_data_o, 64'hDEAD_BEEF_0000_1234);
    end
    checks++;
    if (commit_cnt_o !== 64'd1) begin
      errors++;
      $display("FAIL cnt_after_bypass got %0d required 1", commit_cnt_o);
    end
  endtask

  task automatic test_x0_and_nowren();
    commit_valid_i = 1; commit_wren_i = 1; commit_rdindex_i = 5'd0; commit_data_i = '1;
    rs1_index_i = 5'd0;
    #1;
    checks++;
    if (rs1_data_o !== 64'd0) begin
      errors++;
      $display("FAIL x0_same_cycle got %h required 0", rs1_data_o);
    end
    step();
    idle();
    #1;
    checks++;
    if (rs1_data_o !== 64'd0) begin
      errors++;
      $display("FAIL x0_after got %h required 0", rs1_data_o);
    end
    commit_valid_i = 1; commit_wren_i = 0; commit_rdindex_i = 5'd7; commit_data_i = 64'h1111_2222_3333_4444;
    rs1_index_i = 5'd7;
    #1;
    checks++;
    if (rs1_data_o !== 64'd0) begin
      errors++;
      $display("FAIL nowren_nobypass got %h required 0", rs1_data_o);
    end
    step();
    commit_valid_i = 0; commit_wren_i = 1; commit_rdindex_i = 5'd7; commit_data_i = 64'h5555;
    step();
    idle();
    #1;
    checks++;
    if (rs1_data_o !== 64'd0) begin
      errors++;
      $display("FAIL x7_unchanged got %h required 0", rs1_data_o);
    end
    checks++;
    if (commit_cnt_o !== exp_cnt || exp_cnt !== 64'd3) begin
      errors++;
      $display("FAIL cnt_after_x0 got %0d required 3", commit_cnt_o);
    end
  endtask

  task automatic test_scoreboard();
    disp_valid_i = 1; disp_wren_i = 1; disp_rdindex_i = 5'd3;
    rs2_index_i = 5'd3;
    #1;
    checks++;
    if (rs2_busy_o !== 1'b0) begin
      errors++;
      $display("FAIL disp_same_cycle busy got %b required 0", rs2_busy_o);
    end
    step();
    idle();
    #1;
    checks++;
    if (rs2_busy_o !== 1'b1) begin
      errors++;
      $display("FAIL disp_next_cycle busy got %b required 1", rs2_busy_o);
    end
    commit_valid_i = 1; commit_wren_i = 1; commit_rdindex_i = 5'd3; commit_data_i = 64'h42;
    #1;
    checks++;
    if (rs2_busy_o !== 1'b0 || rs2_data_o !== 64'h42) begin
      errors++;
      $display("FAIL commit_bypass_busy busy=%b data=%h required 0/42", rs2_busy_o, rs2_data_o);
    end
    step();
    idle();
    #1;
    checks++;
    if (rs2_busy_o !== 1'b0 || rs2_data_o !== 64'h42) begin
      errors++;
      $display("FAIL commit_cleared busy=%b data=%h required 0/42", rs2_busy_o, rs2_data_o);
    end
  endtask

  task automatic test_back_to_back();
    disp_valid_i = 1; disp_wren_i = 1; disp_rdindex_i = 5'd9;
    step();
    idle();
    rs1_index_i = 5'd9;
    #1;
    checks++;
    if (rs1_busy_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_busy_set got %b required 1", rs1_busy_o);
    end
    disp_valid_i = 1; disp_wren_i = 1; disp_rdindex_i = 5'd9;
    commit_valid_i = 1; commit_wren_i = 1; commit_rdindex_i = 5'd9; commit_data_i = 64'h99;
    step();
    idle();
    #1;
    checks++;
    if (rs1_busy_o !== 1'b1 || rs1_data_o !== 64'h99) begin
      errors++;
      $display("FAIL b2b_set_wins busy=%b data=%h required 1/99", rs1_busy_o, rs1_data_o);
    end
    commit_valid_i = 1; commit_wren_i = 1; commit_rdindex_i = 5'd9; commit_data_i = 64'h9A;
    step();
    idle();
    #1;
    checks++;
    if (rs1_busy_o !== 1'b0 || rs1_data_o !== 64'h9A) begin
      errors++;
      $display("FAIL b2b_final busy=%b data=%h required 0/9a", rs1_busy_o, rs1_data_o);
    end
  endtask

  task automatic test_flush();
    disp_valid_i = 1; disp_wren_i = 1; disp_rdindex_i = 5'd4;
    step();
    disp_rdindex_i = 5'd10;
    step();
    idle();
    rs1_index_i = 5'd4; rs2_index_i = 5'd10;
    #1;
    checks++;
    if (rs1_busy_o !== 1'b1 || rs2_busy_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre b4=%b b10=%b required 1/1", rs1_busy_o, rs2_busy_o);
    end
    flush_i = 1;
    disp_valid_i = 1; disp_wren_i = 1; disp_rdindex_i = 5'd11;
    commit_valid_i = 1; commit_wren_i = 1; commit_rdindex_i = 5'd4; commit_data_i = 64'h7;
    step();
    idle();
    #1;
    checks++;
    if (rs1_busy_o !== 1'b0 || rs1_data_o !== 64'h7 || rs2_busy_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_post b4=%b x4=%h b10=%b required 0/7/0", rs1_busy_o, rs1_data_o, rs2_busy_o);
    end
    rs1_index_i = 5'd11;
    #1;
    checks++;
    if (rs1_busy_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_disp11 busy got %b required 0", rs1_busy_o);
    end
    checks++;
    if (commit_cnt_o !== exp_cnt) begin
      errors++;
      $display("FAIL cnt_after_flush got %0d required %0d", commit_cnt_o, exp_cnt);
    end
  endtask

  task automatic test_async_reset();
    disp_valid_i = 1; disp_wren_i = 1; disp_rdindex_i = 5'd12;
    step();
    commit_valid_i = 1; commit_wren_i = 1; commit_rdindex_i = 5'd20; commit_data_i = 64'hABCD;
    disp_rdindex_i = 5'd13;
    rs1_index_i = 5'd4; rs2_index_i = 5'd12;
    #2;
    arst_n_i = 0;
    #1;
    checks++;
    if (rs1_data_o !== 64'd0 || rs2_busy_o !== 1'b0 || commit_cnt_o !== 64'd0) begin
      errors++;
      $display("FAIL async_reset x4=%h b12=%b cnt=%0d required 0/0/0", rs1_data_o, rs2_busy_o, commit_cnt_o);
    end
    idle();
    @(negedge clk_i); arst_n_i = 1;
    exp_cnt = '0;
    step();
    rs1_index_i = 5'd5; rs2_index_i = 5'd9;
    #1;
    checks++;
    if (rs1_data_o !== 64'd0 || rs2_data_o !== 64'd0 || commit_cnt_o !== 64'd0) begin
      errors++;
      $display("FAIL post_reset x5=%h x9=%h cnt=%0d required 0/0/0", rs1_data_o, rs2_data_o, commit_cnt_o);
    end
  endtask

  initial begin
    idle();
    arst_n_i = 1; rs1_index_i = '0; rs2_index_i = '0;
    test_reset();
    test_bypass();
    test_x0_and_nowren();
    test_scoreboard();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/int_regfile_sb.md
Name: int_regfile_sb

Overview:
- Integer architectural register file with a busy-bit scoreboard.
- Sits directly downstream of the commit stage and consumes the integer commit channel: valid, wren, data, rdindex.
- Provides two combinational read ports with same-cycle commit bypass to decode/dispatch.
- Tracks which architectural registers have an in-flight writer, and counts committed instructions.

Parameters:
- XLEN, 64, register and data width in bits.
- NREG, 32, number of architectural registers; index width is 5 bits; x0 is hardwired to zero.
- CNTW, 64, width of the commit counter.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- arst_n_i  input  1  reset, asynchronous, active-low.
- commit_valid_i  input  1  commit channel valid; one instruction retires this cycle.
- commit_wren_i  input  1  the retiring instruction writes rd.
- commit_data_i  input  XLEN  result to write.
- commit_rdindex_i  input  5  destination register index.
- disp_valid_i  input  1  one instruction is dispatched this cycle.
- disp_wren_i  input  1  the dispatched instruction writes rd.
- disp_rdindex_i  input  5  destination of the dispatched instruction.
- flush_i  input  1  pipeline flush; discards all in-flight writers.
- rs1_index_i  input  5  read port 1 index.
- rs2_index_i  input  5  read port 2 index.
- rs1_data_o  output  XLEN  read port 1 data.
- rs2_data_o  output  XLEN  read port 2 data.
- rs1_busy_o  output  1  rs1 has a pending writer.
- rs2_busy_o  output  1  rs2 has a pending writer.
- commit_cnt_o  output  CNTW  number of commit_valid_i cycles since reset.

Behaviour:
- Clock/reset: one clock, clk_i. Reset arst_n_i is asynchronous and active-low.
- Reset values: all registers 0, all busy bits 0, commit_cnt_o 0. Read outputs therefore return 0 and busy 0 during and right after reset.
- Reset asserted mid-operation clears all state immediately, regardless of pending commit or dispatch.

Write and commit:
- Write occurs on the clock edge when commit_valid_i && commit_wren_i && commit_rdindex_i != 0: reg[rd] <= commit_data_i.
- A write to x0 is discarded.
- commit_wren_i without commit_valid_i has no effect.
- commit_cnt_o increments by 1 on every cycle with commit_valid_i=1, independent of wren.
- The counter wraps from all-ones to 0.

Reads:
- Reads are combinational.
- Index 0 returns 0.
- If the index equals a same-cycle valid write rd (nonzero), the output is commit_data_i (bypass). Otherwise the output is reg[index].

Scoreboard, priority highest first, evaluated per register each edge:
1. flush_i=1: all busy bits cleared. A same-cycle dispatch does not set busy. A same-cycle commit still writes data.
2. Dispatch set: disp_valid_i && disp_wren_i && rd != 0 sets busy[rd].
   - If a commit clears the same rd in the same cycle, the set wins and busy stays 1 (new writer).
3. Commit clear: a valid commit with wren and rd != 0 clears busy[rd].
- busy[0] is always 0.

Busy outputs:
- rsN_busy_o = busy[rsN] && !(same-cycle valid commit write to rsN).
- The commit bypass makes the value available in the same cycle.
- Same-cycle dispatch does not affect rsN_busy_o; it is visible from the next cycle.

Ordering:
- In-order single-issue commit is assumed by design: at most one in-flight writer per rd.
- A dispatch to an already-busy rd keeps the bit set.

Test Plan:
- Reset then read x1..x31 -> all data 0, busy 0, commit_cnt_o=0.
- Commit valid=1 wren=1 rd=5 data=0xDEAD_BEEF_0000_1234 with rs1_index=5 in the same cycle -> rs1_data_o=0xDEAD_BEEF_0000_1234 combinationally (bypass). Next cycle with no commit -> same value from the array. commit_cnt_o=1.
- Commit rd=0 data=0xFFFF... -> rs1_index=0 reads 0 then and afterwards. Commit valid=1 wren=0 rd=7 -> x7 unchanged, counter increments.
- Dispatch rd=3 -> next cycle rs2_busy_o=1 for index 3. Commit rd=3 data=0x42 -> rs2_busy_o=0 and data=0x42 in the same cycle; busy[3]=0 after the edge.
- Dispatch rd=9 and commit rd=9 in the same cycle while busy[9]=1 -> after the edge busy[9]=1 and x9 = committed data.
- Set busy on x4, x10 -> assert flush_i together with dispatch rd=11 and commit rd=4 data=0x7 -> all busy 0 after the edge, x4=0x7. Assert arst_n_i=0 mid-stream -> all registers, busy bits and the counter read 0 immediately.
